// File: rtl/cmp_sched_pkg.sv
// Shared definitions for the two-requester signed compare scheduler:
// default operand width, operation encodings and result decode.
package cmp_sched_pkg;

  localparam int unsigned DefaultW = 32;

  typedef enum logic [1:0] {
    OP_GE = 2'b00,
    OP_LT = 2'b01,
    OP_EQ = 2'b10,
    OP_NE = 2'b11
  } op_e;

  function automatic logic op_result(op_e op, logic ge, logic eq);
    logic r;
    r = 1'b0;
    unique case (op)
      OP_GE: r = ge;
      OP_LT: r = ~ge;
      OP_EQ: r = eq;
      OP_NE: r = ~eq;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_sched_if.sv
// Request/grant/response bundle between the two requesters and cmp_sched.
interface cmp_sched_if
  import cmp_sched_pkg::*;
#(
  parameter int unsigned W = DefaultW
);

  logic         flush;
  logic         req0;
  logic         req1;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic [1:0]   op0;
  logic [1:0]   op1;
  logic         gnt0;
  logic         gnt1;
  logic         rsp_valid0;
  logic         rsp_valid1;
  logic         rsp_c;

  modport master (
    output flush, req0, req1, a0, b0, a1, b1, op0, op1,
    input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_c
  );

  modport slave (
    input  flush, req0, req1, a0, b0, a1, b1, op0, op1,
    output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_c
  );

endinterface

// File: rtl/signed_ge_cmp.sv
// Combinational two's complement comparator producing A>=B and A==B.
module signed_ge_cmp
  import cmp_sched_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         ge,
  output logic         eq
);

  always_comb begin
    eq = (A == B);
    // Differing signs: the non-negative operand is the larger one.
    if (A[W-1] != B[W-1]) begin
      ge = ~A[W-1];
    end else begin
      ge = (A[W-2:0] >= B[W-2:0]);
    end
  end

endmodule

// File: rtl/cmp_sched.sv
// Round-robin arbiter for two requesters feeding a 2-stage signed compare pipe;
// results return to the owning requester exactly two cycles after grant.
module cmp_sched
  import cmp_sched_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic       clk,
  input  logic       reset,
  cmp_sched_if.slave bus
);

  logic         w_gnt0, w_gnt1, w_gnt;
  logic         w_ge, w_eq, w_res;
  logic         r_ptr;
  logic         r_s1_valid, r_s1_id;
  logic [W-1:0] r_s1_a, r_s1_b;
  op_e          r_s1_op;
  logic         r_s2_valid, r_s2_id, r_s2_c;

  // r_ptr == 1 means requester 1 has priority on a tie.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset && !bus.flush) begin
      w_gnt0 = bus.req0 && (!bus.req1 || !r_ptr);
      w_gnt1 = bus.req1 && (!bus.req0 || r_ptr);
    end
  end

  assign w_gnt = w_gnt0 | w_gnt1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr      <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= 1'b0;
      r_s2_c     <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_ptr   <= w_gnt0;
        r_s1_id <= w_gnt1;
      end
      r_s1_valid <= w_gnt;
      r_s2_valid <= r_s1_valid && !bus.flush;
      r_s2_id    <= r_s1_id;
      r_s2_c     <= r_s1_valid && !bus.flush && w_res;
    end
  end

  // Operands only move on a grant, so idle-port inputs never reach the pipe.
  always_ff @(posedge clk) begin
    if (w_gnt) begin
      r_s1_a  <= w_gnt1 ? bus.a1 : bus.a0;
      r_s1_b  <= w_gnt1 ? bus.b1 : bus.b0;
      r_s1_op <= op_e'(w_gnt1 ? bus.op1 : bus.op0);
    end
  end

  signed_ge_cmp #(
    .W (W)
  ) u_cmp (
    .A  (r_s1_a),
    .B  (r_s1_b),
    .ge (w_ge),
    .eq (w_eq)
  );

  assign w_res = op_result(r_s1_op, w_ge, w_eq);

  assign bus.gnt0       = w_gnt0;
  assign bus.gnt1       = w_gnt1;
  assign bus.rsp_valid0 = r_s2_valid && !r_s2_id;
  assign bus.rsp_valid1 = r_s2_valid && r_s2_id;
  assign bus.rsp_c      = r_s2_c;

endmodule

// File: tb/tb_cmp_sched.sv
// Directed and random checks of cmp_sched arbitration, latency, flush and reset.
module tb_cmp_sched;
  import cmp_sched_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  cmp_sched_if #(.W(W)) bus ();

  cmp_sched #(
    .W (W)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.flush = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  function automatic logic ref_cmp(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    logic ge, eq;
    ge = ($signed(a) >= $signed(b));
    eq = (a == b);
    case (op)
      2'b00:   return ge;
      2'b01:   return !ge;
      2'b10:   return eq;
      default: return !eq;
    endcase
  endfunction

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return W'($urandom_range(0, 3));
      default: return W'($urandom());
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.flush = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_gnt: got %b want 00", {bus.gnt0, bus.gnt1});
    end
    n_chk++;
    if ({bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_rsp: got %b want 000", {bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c});
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_ptr_gnt: got %b want 10", {bus.gnt0, bus.gnt1});
    end
    next_cycle();
  endtask

  task automatic test_lt();
    apply_reset();
    bus.req0 = 1'b1;
    bus.a0   = 32'hFFFF_FFFF;
    bus.b0   = 32'h0000_0001;
    bus.op0  = OP_LT;
    @(negedge clk);
    n_chk++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL lt_gnt: got %b want 10", {bus.gnt0, bus.gnt1});
    end
    next_cycle();
    bus.req0 = 1'b0;
    bus.a0   = 32'h0000_0005;
    bus.op0  = OP_GE;
    @(negedge clk);
    n_chk++;
    if ({bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c} !== 3'b000) begin
      n_fail++;
      $display("FAIL lt_c1: got %b want 000", {bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c});
    end
    next_cycle();
    @(negedge clk);
    n_chk++;
    if ({bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c} !== 3'b101) begin
      n_fail++;
      $display("FAIL lt_rsp: got %b want 101", {bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c});
    end
    next_cycle();
  endtask

  task automatic test_alternate();
    logic [1:0] eg;
    logic [2:0] er;
    apply_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.a0 = 32'd5;
    bus.b0 = 32'd5;
    bus.a1 = 32'h8000_0000;
    bus.b1 = 32'h7FFF_FFFF;
    bus.op0 = OP_GE;
    bus.op1 = OP_GE;
    for (int k = 0; k < 8; k++) begin
      if (k == 6) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      eg = (k >= 6) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
      er = (k < 2) ? 3'b000 : ((k % 2 == 0) ? 3'b101 : 3'b010);
      @(negedge clk);
      n_chk++;
      if ({bus.gnt0, bus.gnt1} !== eg) begin
        n_fail++;
        $display("FAIL alt_gnt[%0d]: got %b want %b", k, {bus.gnt0, bus.gnt1}, eg);
      end
      n_chk++;
      if ({bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c} !== er) begin
        n_fail++;
        $display("FAIL alt_rsp[%0d]: got %b want %b", k,
                 {bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c}, er);
      end
      next_cycle();
    end
  endtask

  // Columns: {req0, req1, flush}; expected {gnt0, gnt1}; expected {rv0, rv1, c}.
  task automatic test_flush();
    logic [2:0] drv [6];
    logic [1:0] eg  [6];
    logic [2:0] er  [6];
    drv = '{3'b100, 3'b111, 3'b110, 3'b000, 3'b001, 3'b000};
    eg  = '{2'b10,  2'b00,  2'b01,  2'b00,  2'b00,  2'b00};
    er  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b000};
    apply_reset();
    bus.a0 = 32'd0;
    bus.b0 = 32'd0;
    bus.op0 = OP_GE;
    bus.a1 = 32'd3;
    bus.b1 = 32'd7;
    bus.op1 = OP_LT;
    for (int k = 0; k < 6; k++) begin
      {bus.req0, bus.req1, bus.flush} = drv[k];
      @(negedge clk);
      n_chk++;
      if ({bus.gnt0, bus.gnt1} !== eg[k]) begin
        n_fail++;
        $display("FAIL flush_gnt[%0d]: got %b want %b", k, {bus.gnt0, bus.gnt1}, eg[k]);
      end
      n_chk++;
      if ({bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c} !== er[k]) begin
        n_fail++;
        $display("FAIL flush_rsp[%0d]: got %b want %b", k,
                 {bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c}, er[k]);
      end
      next_cycle();
    end
  endtask

  // Columns: {reset, req0, req1}.
  task automatic test_midreset();
    logic [2:0] drv [5];
    logic [1:0] eg  [5];
    logic [2:0] er  [5];
    drv = '{3'b110, 3'b000, 3'b101, 3'b100, 3'b100};
    eg  = '{2'b10,  2'b00,  2'b01,  2'b00,  2'b00};
    er  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b011};
    apply_reset();
    bus.a0 = 32'd9;
    bus.b0 = 32'd2;
    bus.op0 = OP_GE;
    bus.a1 = 32'd1;
    bus.b1 = 32'd2;
    bus.op1 = OP_NE;
    for (int k = 0; k < 5; k++) begin
      {reset, bus.req0, bus.req1} = drv[k];
      @(negedge clk);
      n_chk++;
      if ({bus.gnt0, bus.gnt1} !== eg[k]) begin
        n_fail++;
        $display("FAIL mrst_gnt[%0d]: got %b want %b", k, {bus.gnt0, bus.gnt1}, eg[k]);
      end
      n_chk++;
      if ({bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c} !== er[k]) begin
        n_fail++;
        $display("FAIL mrst_rsp[%0d]: got %b want %b", k,
                 {bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c}, er[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_eq_ne();
    logic [1:0] eg [5];
    logic [2:0] er [5];
    eg = '{2'b10,  2'b01,  2'b10,  2'b00,  2'b00};
    er = '{3'b000, 3'b000, 3'b101, 3'b010, 3'b101};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin
          bus.req0 = 1'b1; bus.a0 = 32'h8000_0000; bus.b0 = 32'h8000_0000; bus.op0 = OP_EQ;
        end
        1: begin
          bus.req0 = 1'b0; bus.a0 = 32'h1234_5678; bus.op0 = OP_NE;
          bus.req1 = 1'b1; bus.a1 = 32'h8000_0000; bus.b1 = 32'h8000_0000; bus.op1 = OP_NE;
        end
        2: begin
          bus.req1 = 1'b0; bus.a1 = 32'd0;
          bus.req0 = 1'b1; bus.a0 = 32'd0; bus.b0 = 32'h8000_0000; bus.op0 = OP_GE;
        end
        default: bus.req0 = 1'b0;
      endcase
      @(negedge clk);
      n_chk++;
      if ({bus.gnt0, bus.gnt1} !== eg[k]) begin
        n_fail++;
        $display("FAIL eqne_gnt[%0d]: got %b want %b", k, {bus.gnt0, bus.gnt1}, eg[k]);
      end
      n_chk++;
      if ({bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c} !== er[k]) begin
        n_fail++;
        $display("FAIL eqne_rsp[%0d]: got %b want %b", k,
                 {bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c}, er[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic mp = 1'b0, pg0 = 1'b0, pg1 = 1'b0, eg0, eg1;
    logic m1_v = 1'b0, m1_id = 1'b0, m1_c = 1'b0;
    logic m2_v = 1'b0, m2_id = 1'b0, m2_c = 1'b0;
    int   s0 = 0, s1 = 0;
    apply_reset();
    for (int n = 0; n < 10000; n++) begin
      if (!(bus.req0 && !pg0)) begin
        bus.req0 = ($urandom_range(0, 3) != 0);
        bus.a0   = rand_val();
        bus.b0   = ($urandom_range(0, 3) == 0) ? bus.a0 : rand_val();
        bus.op0  = 2'($urandom_range(0, 3));
      end
      if (!(bus.req1 && !pg1)) begin
        bus.req1 = ($urandom_range(0, 3) != 0);
        bus.a1   = rand_val();
        bus.b1   = ($urandom_range(0, 3) == 0) ? bus.a1 : rand_val();
        bus.op1  = 2'($urandom_range(0, 3));
      end
      bus.flush = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      eg0 = !bus.flush && bus.req0 && (!bus.req1 || !mp);
      eg1 = !bus.flush && bus.req1 && (!bus.req0 || mp);
      n_chk++;
      if ({bus.gnt0, bus.gnt1} !== {eg0, eg1}) begin
        n_fail++;
        $display("FAIL rnd_gnt[%0d]: got %b want %b", n, {bus.gnt0, bus.gnt1}, {eg0, eg1});
      end
      n_chk++;
      if ({bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c} !==
          {m2_v && !m2_id, m2_v && m2_id, m2_v && m2_c}) begin
        n_fail++;
        $display("FAIL rnd_rsp[%0d]: got %b want %b", n,
                 {bus.rsp_valid0, bus.rsp_valid1, bus.rsp_c},
                 {m2_v && !m2_id, m2_v && m2_id, m2_v && m2_c});
      end
      // Starvation tracked from the observed grants.
      if (bus.req0 && bus.gnt1) s0++;
      else if (!bus.req0 || bus.gnt0) s0 = 0;
      if (bus.req1 && bus.gnt0) s1++;
      else if (!bus.req1 || bus.gnt1) s1 = 0;
      n_chk++;
      if (s0 > 1 || s1 > 1) begin
        n_fail++;
        $display("FAIL rnd_starve[%0d]: wait0=%0d wait1=%0d want <=1", n, s0, s1);
        s0 = 0;
        s1 = 0;
      end
      if (bus.flush) begin
        m2_v = 1'b0;
      end else begin
        m2_v  = m1_v;
        m2_id = m1_id;
        m2_c  = m1_c;
      end
      m1_v  = eg0 || eg1;
      m1_id = eg1;
      m1_c  = eg1 ? ref_cmp(bus.op1, bus.a1, bus.b1) : ref_cmp(bus.op0, bus.a0, bus.b0);
      if (eg0) mp = 1'b1;
      else if (eg1) mp = 1'b0;
      pg0 = eg0;
      pg1 = eg1;
      next_cycle();
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.flush = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0 = '0;
    bus.b0 = '0;
    bus.a1 = '0;
    bus.b1 = '0;
    bus.op0 = 2'b00;
    bus.op1 = 2'b00;
    test_reset();
    test_lt();
    test_alternate();
    test_flush();
    test_midreset();
    test_eq_ne();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
